div_arbiter: RTL and testbench

Sequencer and arbiter for the shared 34-cycle iterative divider (radix-2, restoring). It accepts divide requests from two requesters, for example the main pipeline DIV/DIVU path and a second issue slot, and grants them round-robin. It holds the operands stable and drives the divider's start and valid controls, captures quotient and remainder on completion, and returns a tagged response. It also handles per-requester flushes so an aborted instruction never leaves the divider mid-count.

---
 rtl/div_arbiter_pkg.sv | 20 ++
 rtl/div_rr_arb2.sv | 28 ++
 rtl/div_arbiter.sv | 162 ++++++++++++++++
 tb/tb_div_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_arbiter_pkg.sv
// Shared definitions for the divider sequencer/arbiter: FSM encoding,
// divider latency and default widths.
package div_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // RUN cycles from accept to the cycle after dv_complete
  localparam int DIV_LATENCY = 34;
  localparam int TAG_W_DEF   = 4;
  localparam int DATA_W      = 32;

  function automatic logic idx_of(input logic [1:0] onehot);
    return onehot[1];
  endfunction

endpackage

// File: rtl/div_rr_arb2.sv
// Two-way round-robin arbiter; the pointer only moves when both requesters
// contend, so a lone requester never steals the other's next turn.
module div_rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  output logic [1:0] o_grant
);

  logic r_ptr;

  always_comb begin
    o_grant = i_req;
    if (&i_req) begin
      o_grant = r_ptr ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= 1'b0;
    end else if (i_advance) begin
      r_ptr <= o_grant[0];
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Sequencer and round-robin arbiter in front of the shared 34-cycle
// iterative divider, with per-requester flush.
module div_arbiter
  import div_arbiter_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEF,
  parameter int N_REQ = 2
) (
  input  logic              div_clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_signed,
  input  logic [DATA_W-1:0] req0_x,
  input  logic [DATA_W-1:0] req0_y,
  input  logic [TAG_W-1:0]  req0_tag,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_signed,
  input  logic [DATA_W-1:0] req1_x,
  input  logic [DATA_W-1:0] req1_y,
  input  logic [TAG_W-1:0]  req1_tag,
  input  logic              flush0,
  input  logic              flush1,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [TAG_W-1:0]  resp_tag,
  output logic [DATA_W-1:0] resp_q,
  output logic [DATA_W-1:0] resp_r,
  output logic              resp_dz,
  output logic              dv_go,
  output logic              dv_valid,
  output logic              dv_signed,
  output logic [DATA_W-1:0] dv_x,
  output logic [DATA_W-1:0] dv_y,
  input  logic [DATA_W-1:0] dv_s,
  input  logic [DATA_W-1:0] dv_r,
  input  logic              dv_complete,
  output logic              busy
);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [N_REQ-1:0]   w_elig;
  logic [1:0]         w_grant;
  logic               w_accept;
  logic               w_advance;
  logic               w_capture;
  logic               w_flush_own;
  logic               w_sel;
  logic [DATA_W-1:0]  w_sel_y;

  logic               r_owner;
  logic               r_signed;
  logic               r_dz;
  logic [DATA_W-1:0]  r_x;
  logic [DATA_W-1:0]  r_y;
  logic [DATA_W-1:0]  r_q;
  logic [DATA_W-1:0]  r_r;
  logic [TAG_W-1:0]   r_tag;
  logic [5:0]         r_run_cnt;

  // A requester being flushed is not eligible even in IDLE
  assign w_elig      = {req1_valid & ~flush1, req0_valid & ~flush0};
  assign w_advance   = w_accept & (&w_elig);
  assign w_flush_own = r_owner ? flush1 : flush0;
  assign w_sel       = idx_of(w_grant);
  assign w_sel_y     = w_sel ? req1_y : req0_y;

  div_rr_arb2 u_arb (
    .i_clk     (div_clk),
    .i_rst     (reset),
    .i_req     (w_elig),
    .i_advance (w_advance),
    .o_grant   (w_grant)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    dv_go       = 1'b0;
    dv_valid    = 1'b0;
    resp_valid  = 1'b0;
    busy        = 1'b1;
    case (r_state)
      ST_IDLE: begin
        busy       = 1'b0;
        req0_ready = w_grant[0];
        req1_ready = w_grant[1];
        w_accept   = |w_grant;
        if (w_accept) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        dv_go    = 1'b1;
        dv_valid = 1'b1;
        // flush beats a coincident completion
        if (w_flush_own) begin
          w_state_nxt = ST_IDLE;
        end else if (dv_complete) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (w_flush_own || resp_ready) w_state_nxt = ST_IDLE;
      end
      default: begin
        busy        = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge div_clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_owner   <= 1'b0;
      r_signed  <= 1'b0;
      r_dz      <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
      r_q       <= '0;
      r_r       <= '0;
      r_tag     <= '0;
      r_run_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_owner  <= w_sel;
        r_signed <= w_sel ? req1_signed : req0_signed;
        r_x      <= w_sel ? req1_x : req0_x;
        r_y      <= w_sel_y;
        r_tag    <= w_sel ? req1_tag : req0_tag;
        r_dz     <= (w_sel_y == '0);
      end
      if (w_capture) begin
        r_q <= dv_s;
        r_r <= dv_r;
      end
      r_run_cnt <= (r_state == ST_RUN) ? r_run_cnt + 6'd1 : 6'd0;
    end
  end

  assign dv_signed = r_signed;
  assign dv_x      = r_x;
  assign dv_y      = r_y;
  assign resp_id   = r_owner;
  assign resp_tag  = r_tag;
  assign resp_q    = r_q;
  assign resp_r    = r_r;
  assign resp_dz   = r_dz;

  // The divider must finish within its fixed latency once started
  a_run_bounded: assert property (@(posedge div_clk) disable iff (reset)
    (r_state == ST_RUN) |-> (r_run_cnt < 6'(DIV_LATENCY)));

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: behavioural divider model, table vectors,
// hand-written corner sequences and randomized traffic.
module tb_div_arbiter;
  import div_arbiter_pkg::*;

  typedef struct {
    int          id;
    logic        sgn;
    logic [31:0] x;
    logic [31:0] y;
    logic [3:0]  tag;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  logic        div_clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req0_ready, req0_signed = 1'b0;
  logic [31:0] req0_x = '0, req0_y = '0;
  logic [3:0]  req0_tag = '0;
  logic        req1_valid = 1'b0, req1_ready, req1_signed = 1'b0;
  logic [31:0] req1_x = '0, req1_y = '0;
  logic [3:0]  req1_tag = '0;
  logic        flush0 = 1'b0, flush1 = 1'b0;
  logic        resp_valid, resp_ready = 1'b0, resp_id, resp_dz;
  logic [3:0]  resp_tag;
  logic [31:0] resp_q, resp_r;
  logic        dv_go, dv_valid, dv_signed, dv_complete, busy;
  logic [31:0] dv_x, dv_y, dv_s, dv_r;

  int n_cmp = 0;
  int n_bad = 0;

  logic [5:0]  dcnt = '0;
  logic [31:0] dq = '0, dr = '0;
  logic        stray = 1'b0;

  div_arbiter #(.TAG_W(4), .N_REQ(2)) dut (
    .div_clk(div_clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_signed(req0_signed),
    .req0_x(req0_x), .req0_y(req0_y), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_signed(req1_signed),
    .req1_x(req1_x), .req1_y(req1_y), .req1_tag(req1_tag),
    .flush0(flush0), .flush1(flush1),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_tag(resp_tag), .resp_q(resp_q), .resp_r(resp_r), .resp_dz(resp_dz),
    .dv_go(dv_go), .dv_valid(dv_valid), .dv_signed(dv_signed),
    .dv_x(dv_x), .dv_y(dv_y), .dv_s(dv_s), .dv_r(dv_r),
    .dv_complete(dv_complete), .busy(busy)
  );

  always #5 div_clk = ~div_clk;

  // Divide semantics of the external divider: x/0 -> q=all ones, r=x;
  // signed overflow passes through; otherwise truncating division.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] x,
                                          input logic [31:0] y);
    logic [31:0] q, r;
    if (y == 32'd0) begin
      q = 32'hFFFF_FFFF; r = x;
    end else if (sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      q = x; r = 32'd0;
    end else if (sgn) begin
      q = 32'($signed(x) / $signed(y));
      r = 32'($signed(x) % $signed(y));
    end else begin
      q = x / y; r = x % y;
    end
    return {q, r};
  endfunction

  // Divider model: counts while go&valid, samples operands at count 0,
  // signals completion at count 33.
  always @(posedge div_clk) begin
    if (!dv_valid || !dv_go) begin
      dcnt <= 6'd0;
    end else begin
      if (dcnt == 6'd0) {dq, dr} <= ref_div(dv_signed, dv_x, dv_y);
      dcnt <= dcnt + 6'd1;
    end
  end
  assign dv_complete = (dcnt == 6'd33) || stray;
  assign dv_s = dq;
  assign dv_r = dr;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge div_clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic v, input vec_t o);
    if (id == 0) begin
      req0_valid = v; req0_signed = o.sgn; req0_x = o.x; req0_y = o.y; req0_tag = o.tag;
    end else begin
      req1_valid = v; req1_signed = o.sgn; req1_x = o.x; req1_y = o.y; req1_tag = o.tag;
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " ctl"}, 64'({req0_ready, req1_ready, resp_valid, dv_go, dv_valid, busy,
                           resp_id, resp_dz, dv_signed, resp_tag}), 64'd0);
    chk({nm, " q/r"}, {resp_q, resp_r}, 64'd0);
    chk({nm, " x/y"}, {dv_x, dv_y}, 64'd0);
  endtask

  // Wait (bounded) for a ready, require it to be requester id's, take the accept edge.
  task automatic accept(input int id, input string nm);
    int n = 0;
    @(negedge div_clk);
    while (!(req0_ready || req1_ready) && n < 8) begin
      step();
      @(negedge div_clk);
      n++;
    end
    chk({nm, " rdy0"}, 64'(req0_ready), 64'(id == 0));
    chk({nm, " rdy1"}, 64'(req1_ready), 64'(id == 1));
    step();
    if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  // Called in accept cycle T + start; checks latency, payload, hold stability,
  // then either completes the handshake or flushes the owner.
  task automatic expect_resp(input vec_t o, input int hold, input int start,
                             input bit kill, input string nm);
    int n = start;
    while (resp_valid !== 1'b1 && n < DIV_LATENCY + 8) begin
      if (n == 17) begin
        chk({nm, " dv_xy"}, {dv_x, dv_y}, {o.x, o.y});
        chk({nm, " dv_ctl"}, 64'({dv_go, dv_valid, dv_signed, busy}), 64'({2'b11, o.sgn, 1'b1}));
      end
      step();
      n++;
    end
    chk({nm, " latency"}, 64'(n), 64'(DIV_LATENCY));
    chk({nm, " id/tag/dz"}, 64'({resp_id, resp_tag, resp_dz}), 64'({1'(o.id), o.tag, o.dz}));
    chk({nm, " q/r"}, {resp_q, resp_r}, {o.q, o.r});
    for (int i = 0; i < hold; i++) begin
      step();
      @(negedge div_clk);
      chk({nm, " hold"}, 64'({resp_valid, req0_ready, req1_ready, resp_id, resp_tag, resp_dz}),
          64'({1'b1, 1'b0, 1'b0, 1'(o.id), o.tag, o.dz}));
      chk({nm, " hold q/r"}, {resp_q, resp_r}, {o.q, o.r});
    end
    if (kill) begin
      if (o.id == 0) flush0 = 1'b1; else flush1 = 1'b1;
    end else begin
      resp_ready = 1'b1;
    end
    step();
    flush0 = 1'b0; flush1 = 1'b0; resp_ready = 1'b0;
    chk({nm, " idle"}, 64'({resp_valid, busy}), 64'd0);
  endtask

  task automatic run_op(input vec_t o, input int hold, input string nm);
    set_req(o.id, 1'b1, o);
    accept(o.id, nm);
    expect_resp(o, hold, 0, 1'b0, nm);
  endtask

  task automatic no_resp(input int cycles, input string nm);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (resp_valid === 1'b1) seen++;
    end
    chk({nm, " no resp"}, 64'(seen), 64'd0);
  endtask

  function automatic vec_t mk_rand(input int id);
    vec_t o;
    logic [63:0] qr;
    o.id  = id;
    o.sgn = 1'($urandom_range(0, 1));
    o.x   = 32'($urandom);
    o.tag = 4'($urandom_range(0, 15));
    case ($urandom_range(0, 5))
      0: o.y = 32'd0;
      1: o.y = 32'($urandom_range(1, 15));
      2: begin o.x = 32'h8000_0000; o.y = 32'hFFFF_FFFF; end
      3: o.y = 32'($urandom_range(1, 65535));
      default: o.y = 32'($urandom);
    endcase
    qr   = ref_div(o.sgn, o.x, o.y);
    o.q  = qr[63:32];
    o.r  = qr[31:0];
    o.dz = (o.y == 32'd0);
    return o;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[9];
    vec_t a, b, c, ra, rb;
    int   fav;
    int   w;

    vt[0] = '{0, 1'b1, 32'hFFFF_FFF9, 32'd2, 4'd3, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
    vt[1] = '{1, 1'b0, 32'h1234_5678, 32'd0, 4'd5, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1};
    vt[2] = '{0, 1'b0, 32'd100, 32'd7, 4'd1, 32'd14, 32'd2, 1'b0};
    vt[3] = '{1, 1'b0, 32'd9, 32'd3, 4'd2, 32'd3, 32'd0, 1'b0};
    vt[4] = '{0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 4'd7, 32'h8000_0000, 32'd0, 1'b0};
    vt[5] = '{1, 1'b1, 32'hFFFF_FF9C, 32'd7, 4'd9, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0};
    vt[6] = '{0, 1'b0, 32'hFFFF_FFFF, 32'h10, 4'd4, 32'h0FFF_FFFF, 32'hF, 1'b0};
    vt[7] = '{1, 1'b1, 32'hFFFF_FFF9, 32'd0, 4'd6, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1};
    vt[8] = '{0, 1'b0, 32'd7, 32'd9, 4'hA, 32'd0, 32'd7, 1'b0};

    // reset state
    repeat (3) step();
    chk_zero("reset");
    reset = 1'b0;
    step();
    chk_zero("post-reset");

    for (int i = 0; i < 9; i++) run_op(vt[i], i % 3, $sformatf("vec%0d", i));

    // contention: req0 first, then req1 alone; repeat -> req1 first
    a = vt[2]; b = vt[3];
    set_req(0, 1'b1, a); set_req(1, 1'b1, b);
    accept(0, "arb1"); expect_resp(a, 0, 0, 1'b0, "arb1");
    accept(1, "arb2"); expect_resp(b, 0, 0, 1'b0, "arb2");
    set_req(0, 1'b1, a); set_req(1, 1'b1, b);
    accept(1, "arb3"); expect_resp(b, 0, 0, 1'b0, "arb3");
    accept(0, "arb4"); expect_resp(a, 0, 0, 1'b0, "arb4");

    // flush of the non-owner during RUN has no effect
    set_req(0, 1'b1, vt[6]);
    accept(0, "nof");
    repeat (5) step();
    flush1 = 1'b1; step(); flush1 = 1'b0;
    expect_resp(vt[6], 1, 6, 1'b0, "nof");

    // owner flush 10 cycles into RUN, then req1 runs normally
    set_req(0, 1'b1, vt[0]);
    accept(0, "fl");
    repeat (10) step();
    flush0 = 1'b1; step(); flush0 = 1'b0;
    chk("fl stop", 64'({dv_valid, dv_go, busy, resp_valid}), 64'd0);
    no_resp(40, "fl");
    run_op(vt[5], 0, "afterfl");

    // owner flush while the response waits
    set_req(1, 1'b1, vt[1]);
    accept(1, "flresp");
    expect_resp(vt[1], 2, 0, 1'b1, "flresp");
    no_resp(5, "flresp");

    // flush coincident with dv_complete: nothing captured
    run_op(vt[2], 0, "pre");
    set_req(0, 1'b1, vt[6]);
    accept(0, "flcmp");
    repeat (33) step();
    chk("flcmp complete", 64'(dv_complete), 64'd1);
    flush0 = 1'b1; step(); flush0 = 1'b0;
    chk("flcmp idle", 64'({resp_valid, busy, dv_valid}), 64'd0);
    chk("flcmp q kept", {resp_q, resp_r}, {vt[2].q, vt[2].r});
    no_resp(40, "flcmp");

    // stray completion in IDLE is ignored
    stray = 1'b1; step(); stray = 1'b0;
    chk("stray", 64'({resp_valid, busy}), 64'd0);
    chk("stray q", {resp_q, resp_r}, {vt[2].q, vt[2].r});

    // flushed requester is not eligible in IDLE
    flush0 = 1'b1;
    set_req(0, 1'b1, vt[8]);
    @(negedge div_clk);
    chk("idle flush rdy", 64'({req0_ready, req1_ready}), 64'd0);
    step();
    chk("idle flush busy", 64'(busy), 64'd0);
    flush0 = 1'b0;
    accept(0, "idlefl");
    expect_resp(vt[8], 0, 0, 1'b0, "idlefl");

    // reset in cycle 20 of RUN
    set_req(1, 1'b1, vt[3]);
    accept(1, "rstrun");
    repeat (20) step();
    reset = 1'b1; step(); reset = 1'b0;
    chk_zero("rstrun");
    no_resp(40, "rstrun");
    c = '{0, 1'b0, 32'hFFFF_FFFF, 32'h10, 4'd8, 32'h0FFF_FFFF, 32'hF, 1'b0};
    run_op(c, 1, "fresh");

    // randomized traffic; under contention the favoured requester alternates
    fav = 0;
    for (int it = 0; it < 30; it++) begin
      ra = mk_rand(0);
      rb = mk_rand(1);
      if ($urandom_range(0, 2) == 0) begin
        set_req(0, 1'b1, ra); set_req(1, 1'b1, rb);
        w = fav;
        fav = 1 - w;
        accept(w, $sformatf("rnd%0d a", it));
        expect_resp((w == 0) ? ra : rb, int'($urandom_range(0, 2)), 0, 1'b0, $sformatf("rnd%0d a", it));
        accept(1 - w, $sformatf("rnd%0d b", it));
        expect_resp((w == 0) ? rb : ra, int'($urandom_range(0, 2)), 0, 1'b0, $sformatf("rnd%0d b", it));
      end else if ($urandom_range(0, 1) == 0) begin
        run_op(ra, int'($urandom_range(0, 3)), $sformatf("rnd%0d", it));
      end else begin
        run_op(rb, int'($urandom_range(0, 3)), $sformatf("rnd%0d", it));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
